// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM command arbiter.
//   cmd_e      : controller command encodings
//   state_e    : arbiter issue state
//   OWNER_NONE : owner code meaning "no channel owns the data bus"
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WR256 = 2'b01,
    CMD_RD32  = 2'b10,
    CMD_RD256 = 2'b11
  } cmd_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Owner is a channel index (0..7) or OWNER_NONE; 15 is never a channel.
  localparam int               OWN_W      = 4;
  localparam logic [OWN_W-1:0] OWNER_NONE = 4'hF;

endpackage

// File: rtl/sdram_cmd_arbiter_rr_pick.sv
// Rotating-priority picker.
//   req : request mask, one bit per channel
//   ptr : channel that gets first look
//   gnt : one-hot winner (all zero when nothing requests)
//   idx : winner index (0 when nothing requests)
module rr_pick #(
  parameter int NCH = 3,
  parameter int IW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx
);

  always_comb begin
    int   c;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NCH; k++) begin
      c = (int'(ptr) + k) % NCH;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// N-channel command arbiter in front of the SDRAM controller.
// Picks one requesting channel, presents its command/address registered on
// sys_cmd/sys_addr until the controller acknowledges (rising edge of a
// nonzero ack code), then pulses ch_grant and hands the data strobes to that
// channel. Channel 0 can take its address from an internal wrapping scan
// counter (framebuffer fetch) restartable on vsync.
//   clk, rst          : clock, synchronous active-low reset
//   ch_req/cmd/addr   : per-channel request level, command, word address
//   ch_grant          : one-cycle pulse after the channel's command is acked
//   ch_rd/wr_valid    : data strobes routed to the current data owner
//   sys_*             : controller command/address, ack code, data strobes
//   scan_restart/idx  : scan counter restart and current index
//   busy, err         : command outstanding; sticky ack-code mismatch
module sdram_cmd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int             NCH              = 3,
  parameter int             AW               = 23,
  parameter bit             PRIO0            = 1'b1,
  parameter bit             SCAN_EN          = 1'b1,
  parameter int             SCAN_W           = 12,
  parameter int             SCAN_LAST        = 1199,
  parameter logic [AW-1:0]  SCAN_BASE        = AW'(23'h400000),
  parameter int             SCAN_STRIDE_LOG2 = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          ch_req,
  input  logic [NCH-1:0][1:0]     ch_cmd,
  input  logic [NCH-1:0][AW-1:0]  ch_addr,
  output logic [NCH-1:0]          ch_grant,
  output logic [NCH-1:0]          ch_rd_valid,
  output logic [NCH-1:0]          ch_wr_valid,
  output logic [1:0]              sys_cmd,
  output logic [AW-1:0]           sys_addr,
  input  logic [1:0]              sys_cmd_ack,
  input  logic                    sys_rd_data_valid,
  input  logic                    sys_wr_data_valid,
  input  logic                    scan_restart,
  output logic [SCAN_W-1:0]       scan_idx,
  output logic                    busy,
  output logic                    err
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e           state;
  logic             ack_prev;
  logic             do_ack;
  logic [IW-1:0]    win;
  logic [IW-1:0]    rr_ptr, rr_nxt;
  logic [OWN_W-1:0] owner;
  logic [NCH-1:0]   req_m, rr_set, pk_gnt;
  logic [IW-1:0]    pk_idx, sel;
  logic             sel_any, sel_rr;
  logic [SCAN_W-1:0] scan_nxt;
  logic [AW-1:0]    ch0_addr, ld_addr;

  // Ack counts once per transition out of 00, and only while a command is out.
  assign do_ack = (state == ISSUE) && ack_prev && (sys_cmd_ack != CMD_NOP);
  assign busy   = (state == ISSUE);

  // The channel being acked (and one still seeing its grant pulse) has not
  // dropped its request yet; keep it out of the next pick so it is not
  // issued twice.
  always_comb begin
    req_m = ch_req & ~ch_grant;
    if (do_ack) req_m[win] = 1'b0;
    rr_set = req_m;
    if (PRIO0) rr_set[0] = 1'b0;
  end

  rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .req (rr_set),
    .ptr (rr_ptr),
    .gnt (pk_gnt),
    .idx (pk_idx)
  );

  always_comb begin
    if (PRIO0 && req_m[0]) begin
      sel = '0; sel_any = 1'b1; sel_rr = 1'b0;
    end else begin
      sel = pk_idx; sel_any = |pk_gnt; sel_rr = 1'b1;
    end
    if (sel == IW'(NCH - 1)) rr_nxt = PRIO0 ? IW'(1) : '0;
    else                     rr_nxt = sel + IW'(1);
  end

  // Restart beats a same-cycle increment.
  always_comb begin
    scan_nxt = scan_idx;
    if (do_ack && win == '0)
      scan_nxt = (scan_idx == SCAN_W'(SCAN_LAST)) ? '0 : scan_idx + SCAN_W'(1);
    if (scan_restart || !SCAN_EN) scan_nxt = '0;
  end

  // Channel 0 address is taken from the index that is live while the
  // command sits on the bus.
  assign ch0_addr = SCAN_EN ? SCAN_BASE + (AW'(scan_nxt) << SCAN_STRIDE_LOG2)
                            : ch_addr[0];
  assign ld_addr  = (sel == '0) ? ch0_addr : ch_addr[sel];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      sys_cmd  <= CMD_NOP;
      sys_addr <= '0;
      win      <= '0;
      owner    <= OWNER_NONE;
      ch_grant <= '0;
      scan_idx <= '0;
      rr_ptr   <= IW'(1);
      err      <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      ack_prev <= (sys_cmd_ack == CMD_NOP);
      ch_grant <= '0;
      scan_idx <= scan_nxt;
      if (do_ack) begin
        ch_grant[win] <= 1'b1;
        owner         <= OWN_W'(win);
        if (sys_cmd_ack != sys_cmd) err <= 1'b1;
      end
      // A new winner may load in the ack cycle itself (pipelined issue).
      if (state == IDLE || do_ack) begin
        if (sel_any) begin
          state    <= ISSUE;
          sys_cmd  <= ch_cmd[sel];
          sys_addr <= ld_addr;
          win      <= sel;
          if (sel_rr) rr_ptr <= rr_nxt;
        end else begin
          state   <= IDLE;
          sys_cmd <= CMD_NOP;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_rd_valid[i] = sys_rd_data_valid && (owner == OWN_W'(i));
      ch_wr_valid[i] = sys_wr_data_valid && (owner == OWN_W'(i));
    end
  end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
module tb_sdram_cmd_arbiter;

  localparam int             NCH   = 3;
  localparam int             AW    = 23;
  localparam bit             PRIO0 = 1'b1;
  localparam bit             SCAN_EN = 1'b1;
  localparam int             SCAN_W = 12;
  localparam int             SCAN_LAST = 1199;
  localparam logic [AW-1:0]  SCAN_BASE = 23'h400000;
  localparam int             STRIDE = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NCH-1:0]         ch_req;
  logic [NCH-1:0][1:0]    ch_cmd;
  logic [NCH-1:0][AW-1:0] ch_addr;
  logic [NCH-1:0]         ch_grant, ch_rd_valid, ch_wr_valid;
  logic [1:0]             sys_cmd;
  logic [AW-1:0]          sys_addr;
  logic [1:0]             sys_cmd_ack;
  logic                   sys_rd_data_valid, sys_wr_data_valid;
  logic                   scan_restart;
  logic [SCAN_W-1:0]      scan_idx;
  logic                   busy, err;

  sdram_cmd_arbiter #(
    .NCH(NCH), .AW(AW), .PRIO0(PRIO0), .SCAN_EN(SCAN_EN), .SCAN_W(SCAN_W),
    .SCAN_LAST(SCAN_LAST), .SCAN_BASE(SCAN_BASE), .SCAN_STRIDE_LOG2(STRIDE)
  ) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_cmd(ch_cmd), .ch_addr(ch_addr),
    .ch_grant(ch_grant), .ch_rd_valid(ch_rd_valid), .ch_wr_valid(ch_wr_valid),
    .sys_cmd(sys_cmd), .sys_addr(sys_addr), .sys_cmd_ack(sys_cmd_ack),
    .sys_rd_data_valid(sys_rd_data_valid), .sys_wr_data_valid(sys_wr_data_valid),
    .scan_restart(scan_restart), .scan_idx(scan_idx), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_hold = 0;

  // Reference model: what is on the bus, who it belongs to, who owns data.
  int     m_cmd, m_busy, m_win, m_owner, m_scan, m_rr, m_err, m_pz, m_grant;
  longint m_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int doack, w, c, n;
    if (!rst) begin
      m_cmd = 0; m_addr = 0; m_busy = 0; m_win = 0; m_owner = -1;
      m_scan = 0; m_rr = 1; m_err = 0; m_pz = 0; m_grant = -1;
      return;
    end
    doack = (m_busy != 0) && (m_pz != 0) && (sys_cmd_ack != 2'b00);
    m_pz = (sys_cmd_ack == 2'b00);
    m_grant = -1;
    n = m_scan;
    if (doack) begin
      m_grant = m_win;
      m_owner = m_win;
      if (int'(sys_cmd_ack) != m_cmd) m_err = 1;
      if (SCAN_EN && m_win == 0) n = (m_scan + 1) % (SCAN_LAST + 1);
    end
    if (scan_restart) n = 0;
    m_scan = n;
    if (!m_busy || doack) begin
      // The channel just acked is consumed and cannot be picked again.
      w = -1;
      if (PRIO0 && ch_req[0] && !(doack && m_win == 0)) w = 0;
      else
        for (int k = 0; k < NCH; k++) begin
          c = (m_rr + k) % NCH;
          if (w < 0 && ch_req[c] && !(PRIO0 && c == 0) && !(doack && m_win == c)) w = c;
        end
      if (w >= 0) begin
        if (!(PRIO0 && w == 0)) begin
          m_rr = (w + 1) % NCH;
          if (PRIO0 && m_rr == 0) m_rr = 1;
        end
        m_win = w; m_cmd = int'(ch_cmd[w]); m_busy = 1;
        if (SCAN_EN && w == 0)
          m_addr = (longint'(SCAN_BASE) + (longint'(n) << STRIDE)) % (longint'(1) << AW);
        else
          m_addr = longint'(ch_addr[w]);
      end else begin
        m_busy = 0; m_cmd = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] eg, er, ew;
    eg = (m_grant >= 0) ? (64'd1 << m_grant) : 64'd0;
    er = (m_owner >= 0 && sys_rd_data_valid) ? (64'd1 << m_owner) : 64'd0;
    ew = (m_owner >= 0 && sys_wr_data_valid) ? (64'd1 << m_owner) : 64'd0;
    chk("sys_cmd",  64'(sys_cmd),  64'(m_cmd));
    chk("sys_addr", 64'(sys_addr), 64'(m_addr));
    chk("busy",     64'(busy),     64'(m_busy));
    chk("err",      64'(err),      64'(m_err));
    chk("scan_idx", 64'(scan_idx), 64'(m_scan));
    chk("ch_grant", 64'(ch_grant), eg);
    chk("ch_rd_valid", 64'(ch_rd_valid), er);
    chk("ch_wr_valid", 64'(ch_wr_valid), ew);
  endtask

  // One clock: model advances on the edge, outputs compared 1 time unit
  // later, then the channels/controller react and pulse inputs fall.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    for (int i = 0; i < NCH; i++) if (ch_grant[i]) ch_req[i] = 1'b0;
    if (ack_hold > 0) begin
      ack_hold--;
      if (ack_hold == 0) sys_cmd_ack = 2'b00;
    end
    sys_rd_data_valid = 1'b0;
    sys_wr_data_valid = 1'b0;
    scan_restart      = 1'b0;
  endtask

  task automatic ack(input logic [1:0] code, input int hold);
    sys_cmd_ack = code;
    ack_hold    = hold;
  endtask

  initial begin
    int g;
    rst = 1'b0; ch_req = '0; ch_cmd = '0; ch_addr = '0; sys_cmd_ack = 2'b00;
    sys_rd_data_valid = 1'b0; sys_wr_data_valid = 1'b0; scan_restart = 1'b0;
    tick(); tick();
    chk("rst_cmd", 64'(sys_cmd), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_scan", 64'(scan_idx), 0);
    rst = 1'b1;
    tick();

    // Fixed priority of channel 0, then ch2 issued straight from the ack.
    ch_cmd[0] = 2'b10; ch_cmd[2] = 2'b11; ch_addr[2] = 23'h012345;
    ch_req = 3'b101;
    tick();
    chk("prio_cmd", 64'(sys_cmd), 64'h2);
    chk("prio_addr", 64'(sys_addr), 64'h400000);
    ack(2'b10, 1);
    tick();
    chk("prio_grant", 64'(ch_grant), 64'b001);
    chk("prio_scan", 64'(scan_idx), 64'd1);
    chk("prio_cmd2", 64'(sys_cmd), 64'h3);
    chk("prio_addr2", 64'(sys_addr), 64'h012345);
    tick();
    ack(2'b11, 1);
    tick();
    chk("prio_grant2", 64'(ch_grant), 64'b100);
    tick();

    // Round-robin between ch1 and ch2 held requesting.
    ch_cmd[1] = 2'b10; ch_addr[1] = 23'h000777; ch_cmd[2] = 2'b11;
    ch_req = 3'b110;
    tick();
    for (int n = 0; n < 4; n++) begin
      ack(sys_cmd, 1);
      tick();
      chk($sformatf("rr_grant%0d", n), 64'(ch_grant), (n % 2 == 0) ? 64'b010 : 64'b100);
      tick();
      if (n < 3) ch_req = ch_req | 3'b110;
    end
    ch_req = '0;
    ack(sys_cmd, 1);
    tick(); tick();

    // Long ack counts once.
    ch_cmd[1] = 2'b11; ch_req = 3'b010;
    tick();
    ack(2'b11, 5);
    g = 0;
    for (int i = 0; i < 7; i++) begin tick(); g += $countones(ch_grant); end
    chk("ack_once", 64'(g), 64'd1);

    // Steering: ch1 write burst, then ch2 takes the strobes.
    ch_cmd[1] = 2'b01; ch_req = 3'b010;
    tick();
    ack(2'b01, 1);
    tick(); tick();
    g = 0;
    for (int i = 0; i < 128; i++) begin
      sys_wr_data_valid = 1'b1;
      tick();
      if (ch_wr_valid == 3'b010) g++;
    end
    chk("steer_wr_ch1", 64'(g), 64'd128);
    ch_cmd[2] = 2'b10; ch_req = 3'b100;
    tick();
    ack(2'b10, 1);
    sys_rd_data_valid = 1'b1; sys_wr_data_valid = 1'b1;
    tick();
    chk("steer_rd_ch2", 64'(ch_rd_valid), 64'b100);
    chk("steer_wr_ch2", 64'(ch_wr_valid), 64'b100);
    tick();

    // Mismatched ack code sets sticky err.
    ch_cmd[1] = 2'b01; ch_req = 3'b010;
    tick();
    ack(2'b11, 1);
    tick();
    chk("err_set", 64'(err), 64'd1);
    tick(); tick(); tick();
    chk("err_sticky", 64'(err), 64'd1);

    // Reset in the middle of a ch1 read burst.
    ch_cmd[1] = 2'b11; ch_req = 3'b010;
    tick();
    ack(2'b11, 1);
    tick(); tick();
    sys_rd_data_valid = 1'b1;
    tick();
    chk("burst_rd_ch1", 64'(ch_rd_valid), 64'b010);
    sys_rd_data_valid = 1'b1; rst = 1'b0;
    tick();
    chk("rst_rd_valid", 64'(ch_rd_valid), 0);
    chk("rst_cmd2", 64'(sys_cmd), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_scan2", 64'(scan_idx), 0);
    rst = 1'b1;
    tick();

    // Scan counter wraps after SCAN_LAST+1 channel-0 acks.
    ch_cmd[0] = 2'b10;
    for (int i = 0; i <= SCAN_LAST; i++) begin
      ch_req[0] = 1'b1;
      tick();
      if (i == SCAN_LAST) chk("scan_addr_last", 64'(sys_addr), 64'h400000 + 64'd9592);
      ack(2'b10, 1);
      tick();
      tick();
    end
    chk("scan_wrap", 64'(scan_idx), 0);
    ch_req[0] = 1'b1;
    tick();
    ack(2'b10, 1);
    tick(); tick();
    chk("scan_one", 64'(scan_idx), 64'd1);
    ch_req[0] = 1'b1;
    tick();
    ack(2'b10, 1);
    scan_restart = 1'b1;
    tick();
    chk("scan_restart_wins", 64'(scan_idx), 0);
    tick();

    // Random traffic against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < NCH; i++)
        if (!ch_req[i] && !ch_grant[i] && $urandom_range(0, 3) == 0) begin
          ch_req[i]  = 1'b1;
          ch_cmd[i]  = 2'($urandom_range(1, 3));
          ch_addr[i] = AW'($urandom);
        end
      if (sys_cmd_ack == 2'b00 && ack_hold == 0 && sys_cmd != 2'b00 && $urandom_range(0, 2) == 0)
        ack(($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : sys_cmd,
            int'($urandom_range(1, 4)));
      sys_rd_data_valid = 1'($urandom_range(0, 1));
      sys_wr_data_valid = 1'($urandom_range(0, 1));
      scan_restart      = ($urandom_range(0, 99) == 0);
      rst               = !($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Parametrised N-channel command arbiter in front of the SDRAM_16bit controller; replaces the fixed three-way video/cache priority logic in the top level.
- Arbitrates channel requests into one registered sys_cmd/sys_addr pair and detects acknowledge edges.
- Steers rd/wr data-valid strobes to the channel that owns the current burst.
- Channel 0 optionally runs from an internal wrapping scan counter (framebuffer fetch), restartable on vsync.

Parameters:
- NCH, 3, number of channels (2..8).
- AW, 23, SDRAM word-address width.
- PRIO0, 1, 1 = channel 0 has fixed top priority; 0 = channel 0 joins round-robin.
- SCAN_EN, 1, 1 = channel 0 address comes from the internal scan counter; ch_addr[0] is ignored.
- SCAN_W, 12, scan counter width.
- SCAN_LAST, 1199, last scan index before wrap to 0.
- SCAN_BASE, 23'h400000, word address of scan index 0.
- SCAN_STRIDE_LOG2, 3, scan address = SCAN_BASE + (index << SCAN_STRIDE_LOG2).

Ports:
- clk  in  1  single clock, the SDRAM clock domain.
- rst  in  1  synchronous, active-low reset.
- ch_req  in  NCH  per-channel request level; held until grant.
- ch_cmd  in  2*NCH  per-channel command: 01 write 256B, 10 read 32B, 11 read 256B; 00 is illegal while requesting.
- ch_addr  in  AW*NCH  per-channel word address.
- ch_grant  out  NCH  one-cycle pulse to the winning channel when its command is acked.
- ch_rd_valid  out  NCH  sys_rd_data_valid routed to the data owner.
- ch_wr_valid  out  NCH  sys_wr_data_valid routed to the data owner.
- sys_cmd  out  2  command to the controller.
- sys_addr  out  AW  address to the controller.
- sys_cmd_ack  in  2  controller acknowledge code.
- sys_rd_data_valid  in  1  controller read-data strobe.
- sys_wr_data_valid  in  1  controller write-data strobe.
- scan_restart  in  1  synchronous restart of the scan counter (vsync).
- scan_idx  out  SCAN_W  current scan index.
- busy  out  1  a command is issued and not yet acked.
- err  out  1  sticky: the ack code did not match the issued command.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; sys_cmd=00; sys_addr=0; owner=none; ch_grant, ch_rd_valid, ch_wr_valid=0; scan_idx=0; rr_ptr=1; busy=0; err=0.
  - Takes effect mid-burst too: valid strobes are dropped, no grant is issued.
- Ack detect: ack_prev registers (sys_cmd_ack==00). An ack event is ack_prev=1 and sys_cmd_ack!=00. Nonzero ack held for several cycles counts once.
- IDLE:
  - If any ch_req: pick the winner, load sys_cmd=ch_cmd[w] and sys_addr, go to ISSUE, busy=1. sys_cmd is visible 1 cycle after the request is sampled.
  - With no request, sys_cmd=00.
- Selection order:
  - PRIO0=1 and ch_req[0]=1 -> channel 0 wins.
  - Otherwise the first requester scanning rr_ptr, rr_ptr+1, ... with wrap over the round-robin set. The set is 1..NCH-1 when PRIO0=1, else 0..NCH-1.
  - rr_ptr advances to winner+1 (wrapped) on a round-robin grant only.
- ISSUE:
  - Holds sys_cmd/sys_addr until an ack event, even if ch_req drops.
  - On the ack event:
    - ch_grant[w] pulses for 1 cycle; owner<=w.
    - err is set if sys_cmd_ack!=sys_cmd.
    - sys_cmd returns to 00 on the next edge unless a new winner is loaded. Back-to-back issue from the ack cycle is allowed (pipelined), so state goes to IDLE or directly to ISSUE.
- Data steering (combinational from owner):
  - ch_rd_valid[owner]=sys_rd_data_valid; ch_wr_valid[owner]=sys_wr_data_valid; all other bits 0.
  - Owner persists until the next ack event.
  - Owner=none -> all 0.
- Scan (SCAN_EN=1):
  - Channel 0 address = SCAN_BASE + (scan_idx<<SCAN_STRIDE_LOG2), truncated to AW.
  - On a channel-0 ack event scan_idx increments; SCAN_LAST wraps to 0.
  - scan_restart forces 0 and wins over a simultaneous increment.
  - scan_restart during ISSUE does not change the sys_addr already loaded.

Decomposition:
- Shared package sdram_arb_pkg: command encodings (NOP=00, WR256=01, RD32=10, RD256=11), state enum {IDLE, ISSUE}, owner "none" encoding.
- One natural sub-module: rr_pick (combinational rotating-priority picker: NCH-wide req mask + pointer -> one-hot winner plus index).

Test Plan:
- Reset mid-burst: ch1 owner, rd_valid streaming, rst=0 for 1 cycle -> ch_rd_valid=0 from that edge; sys_cmd=00; err=0; scan_idx=0.
- Priority: ch0(10) and ch2(11) requested together, PRIO0=1 -> sys_cmd=10, sys_addr=23'h400000; after ack=10, ch_grant=001 and scan_idx=1; then sys_cmd=11 with ch2's address.
- Round-robin: ch1 and ch2 held requesting, ack 4 times -> grants alternate 010,100,010,100.
- Scan wrap: 1200 channel-0 acks -> scan_idx returns to 0; address at index 1199 is 23'h400000+9592. scan_restart on the same cycle as an ack -> scan_idx=0.
- Ack edge/mismatch: ack=11 held for 5 cycles -> exactly one grant. Issued 01 acked with 11 -> err=1, stays 1 until reset.
- Steering: ch1 WR256 acked, 128 sys_wr_data_valid pulses -> only ch_wr_valid[1] toggles; ch2 acked next -> valids move to ch2 from the ack cycle.
